// File: rtl/intr_req_ctrl.sv
// Interrupt request controller: edge-latched sources, mask, fixed priority, INTR handshake.
// Optional macro INTR_SYNC_EN adds a 2-flop synchronizer on INT_IN ahead of edge detect.
module intr_req_ctrl #(
    parameter int N_SRC = 4,
    parameter int VEC_W = 2
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [N_SRC-1:0] INT_IN,
    input  logic             MASK_WE,
    input  logic [N_SRC-1:0] MASK_IN,
    input  logic             INT_ACK,
    input  logic             INT_DONE,
    output logic             INTR,
    output logic [VEC_W-1:0] VEC_ID,
    output logic [N_SRC-1:0] PENDING,
    output logic             IN_SERVICE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    if ((N_SRC < 1) || (N_SRC > 8) || ((2 ** VEC_W) < N_SRC)) begin : g_bad_param
        $error("intr_req_ctrl: bad N_SRC/VEC_W combination");
    end

    state_t           state_q;
    state_t           state_d;
    logic [VEC_W-1:0] vec_q;
    logic [VEC_W-1:0] vec_d;
    logic [N_SRC-1:0] pend_q;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] in_s;
    logic [N_SRC-1:0] event_w;
    logic [N_SRC-1:0] elig;

`ifdef INTR_SYNC_EN
    logic [N_SRC-1:0] sync_q1;
    logic [N_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (RST) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= INT_IN;
            sync_q2 <= sync_q1;
        end
    end

    assign in_s = sync_q2;
`else
    assign in_s = INT_IN;
`endif

    assign event_w = in_s & ~prev_q;
    assign elig    = pend_q & mask_q;

    function automatic logic [VEC_W-1:0] prio(input logic [N_SRC-1:0] v);
        prio = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                prio = VEC_W'(i);
            end
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        pend_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (elig != '0) begin
                    vec_d   = prio(elig);
                    state_d = REQ;
                end
            end
            REQ: begin
                // ACK outranks DONE and the mask-off retreat
                if (INT_ACK) begin
                    pend_clr = N_SRC'(1) << vec_q;
                    state_d  = SVC;
                end else if (!elig[vec_q]) begin
                    state_d = IDLE;
                end
            end
            SVC: begin
                if (INT_DONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            vec_q   <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            prev_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            // a fresh event wins over a same-cycle ACK clear
            pend_q  <= (pend_q & ~pend_clr) | event_w;
            prev_q  <= in_s;
            if (MASK_WE) begin
                mask_q <= MASK_IN;
            end
        end
    end

    assign INTR       = (state_q == REQ);
    assign IN_SERVICE = (state_q == SVC);
    assign VEC_ID     = vec_q;
    assign PENDING    = pend_q;

endmodule
